// File: rtl/stream_uart_pkg.sv
// Shared definitions for the stream-to-UART transmitter: FSM encoding,
// parity selectors, end-of-line characters and the baud divisor helper.
package stream_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [7:0] EOL_CR = 8'h0D;
    localparam logic [7:0] EOL_LF = 8'h0A;

    // Rounded clock cycles per bit.
    function automatic int calc_div(input int clk_freq_hz, input int baud);
        return (clk_freq_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/stream_uart_fifo.sv
// Synchronous FIFO with one spare pointer bit to tell full from empty and
// a registered read port that updates on every pop.
module stream_uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = rdata_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rdata_reg  <= mem[rd_ptr_reg[AW-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_uart_tx.sv
// Stream-to-UART transmitter: FIFO-buffered bytes serialised LSB first with
// optional parity, one or two stop bits and CR/LF insertion after tlast.
module stream_uart_tx
    import stream_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD        = 57600,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int EOL_MODE    = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_tdata,
    input  logic                          i_tlast,
    input  logic                          i_tvalid,
    output logic                          o_tready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_MAX   = CW'(DIV - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("stream_uart_tx: clock too slow for requested baud rate");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("stream_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("stream_uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t   state_reg, state_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic          stop_idx_reg, stop_idx_next;
    logic [1:0]    eol_cnt_reg, eol_cnt_next;
    logic          src_fifo_reg, src_fifo_next;
    logic [7:0]    eol_char_reg, eol_char_next;
    logic          tx_reg, tx_next;
    logic          tready_reg;

    logic          push;
    logic          pop;
    logic [8:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] level_next;
    logic [7:0]    cur_byte;
    logic          parity_bit;
    logic          bit_tick;

    assign push = i_tvalid & tready_reg & ~fifo_full;

    stream_uart_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata ({i_tlast, i_tdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The popped byte stays in the FIFO read register for the whole frame.
    assign cur_byte   = src_fifo_reg ? fifo_rdata[7:0] : eol_char_reg;
    assign parity_bit = (^cur_byte) ^ (PARITY == PAR_ODD);
    assign bit_tick   = (baud_cnt_reg == '0);
    assign level_next = fifo_level + LW'(push) - LW'(pop);

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        eol_cnt_next  = eol_cnt_reg;
        src_fifo_next = src_fifo_reg;
        eol_char_next = eol_char_reg;
        pop           = 1'b0;
        tx_next       = 1'b1;

        if (state_reg != ST_IDLE) begin
            baud_cnt_next = bit_tick ? BAUD_MAX : baud_cnt_reg - 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (eol_cnt_reg != 2'd0) begin
                    eol_char_next = (eol_cnt_reg == 2'd2) ? EOL_CR : EOL_LF;
                    eol_cnt_next  = eol_cnt_reg - 2'd1;
                    src_fifo_next = 1'b0;
                    baud_cnt_next = BAUD_MAX;
                    state_next    = ST_START;
                end else if (!fifo_empty) begin
                    pop           = 1'b1;
                    src_fifo_next = 1'b1;
                    baud_cnt_next = BAUD_MAX;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_tick) begin
                    bit_idx_next = 3'd0;
                    state_next   = ST_DATA;
                    if (EOL_MODE == 1 && src_fifo_reg && fifo_rdata[8]) begin
                        eol_cnt_next = 2'd2;
                    end
                end
            end
            ST_DATA: begin
                tx_next = cur_byte[bit_idx_reg];
                if (bit_tick) begin
                    stop_idx_next = 1'b0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                tx_next = parity_bit;
                if (bit_tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_reg == LAST_STOP) begin
                        state_next = ST_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Line and ready are registered so the pin never glitches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            eol_cnt_reg  <= '0;
            src_fifo_reg <= 1'b0;
            eol_char_reg <= '0;
            tx_reg       <= 1'b1;
            tready_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            eol_cnt_reg  <= eol_cnt_next;
            src_fifo_reg <= src_fifo_next;
            eol_char_reg <= eol_char_next;
            tx_reg       <= tx_next;
            tready_reg   <= (level_next != FULL_LEVEL);
        end
    end

    assign o_uart_tx = tx_reg;
    assign o_tready  = tready_reg;
    assign o_level   = fifo_level;
    assign o_busy    = (state_reg != ST_IDLE) || !fifo_empty || (eol_cnt_reg != 2'd0);

endmodule

// File: tb/tb_stream_uart_tx.sv
// Directed bench for stream_uart_tx: several parameterisations share one
// clock and reset; each step compares line/handshake behaviour to hand values.
module tb_stream_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata [5];
    logic [4:0] tlast = '0;
    logic [4:0] tvalid = '0;
    wire  [4:0] tready;
    wire  [4:0] tx;
    wire  [4:0] busy;
    wire  [2:0] lvl0;
    wire  [4:0] lvl1, lvl2, lvl3, lvl4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_low = 0;
    int mon_k = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && busy[mon_k] !== 1'b1) busy_low <= busy_low + 1;

    stream_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(4),
                     .PARITY(0), .STOP_BITS(1), .EOL_MODE(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[0]), .i_tlast(tlast[0]),
        .i_tvalid(tvalid[0]), .o_tready(tready[0]), .o_uart_tx(tx[0]),
        .o_busy(busy[0]), .o_level(lvl0));
    stream_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(16),
                     .PARITY(1), .STOP_BITS(1), .EOL_MODE(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[1]), .i_tlast(tlast[1]),
        .i_tvalid(tvalid[1]), .o_tready(tready[1]), .o_uart_tx(tx[1]),
        .o_busy(busy[1]), .o_level(lvl1));
    stream_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(16),
                     .PARITY(2), .STOP_BITS(1), .EOL_MODE(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[2]), .i_tlast(tlast[2]),
        .i_tvalid(tvalid[2]), .o_tready(tready[2]), .o_uart_tx(tx[2]),
        .o_busy(busy[2]), .o_level(lvl2));
    stream_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(16),
                     .PARITY(0), .STOP_BITS(1), .EOL_MODE(1)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[3]), .i_tlast(tlast[3]),
        .i_tvalid(tvalid[3]), .o_tready(tready[3]), .o_uart_tx(tx[3]),
        .o_busy(busy[3]), .o_level(lvl3));
    stream_uart_tx #(.CLK_FREQ_HZ(16000000), .BAUD(1000000), .FIFO_DEPTH(16),
                     .PARITY(0), .STOP_BITS(2), .EOL_MODE(0)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[4]), .i_tlast(tlast[4]),
        .i_tvalid(tvalid[4]), .o_tready(tready[4]), .o_uart_tx(tx[4]),
        .o_busy(busy[4]), .o_level(lvl4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Offer one byte; returns the cycle number of the accepting edge.
    task automatic send(input int k, input logic [7:0] d, input logic last, output int acc);
        int  t;
        logic rdy;
        t = 0;
        tdata[k] = d;
        tlast[k] = last;
        tvalid[k] = 1'b1;
        do begin
            rdy = tready[k];
            tick();
            t++;
        end while (!rdy && t < 500);
        tvalid[k] = 1'b0;
        tlast[k] = 1'b0;
        acc = cyc;
        check("send_accept", {31'd0, rdy}, 32'd1);
    endtask

    // Decode one frame by mid-bit sampling; start_cyc is the first low sample.
    task automatic recv(input int k, input int npar, input int nstop,
                        output logic [7:0] d, output logic p, output int start_cyc);
        int t;
        t = 0;
        d = '0;
        p = 1'b0;
        while (tx[k] !== 1'b0 && t < 3000) begin
            tick();
            t++;
        end
        check("recv_start_seen", {31'd0, t < 3000}, 32'd1);
        start_cyc = cyc;
        repeat (7) tick();
        check("recv_start_mid", {31'd0, tx[k]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) tick();
            d[i] = tx[k];
        end
        if (npar != 0) begin
            repeat (16) tick();
            p = tx[k];
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (16) tick();
            check("recv_stop", {31'd0, tx[k]}, 32'd1);
        end
    endtask

    logic [7:0] b4 [6];
    logic [7:0] rx4 [6];
    int         acc4 [6];

    initial begin
        int acc, acc2, s1, s2, s3, glitch, t;
        logic [9:0] frame;
        logic [7:0] d;
        logic p, rdy;

        for (int i = 0; i < 5; i++) tdata[i] = 8'h00;
        b4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset state
        repeat (3) tick();
        check("rst_tx", {31'd0, tx[0]}, 32'd1);
        check("rst_tready", {31'd0, tready[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_level", {29'd0, lvl0}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_tready_before_edge", {31'd0, tready[0]}, 32'd0);
        tick();
        check("rel_tready_first_edge", {27'd0, tready}, 32'h1F);

        // 8N1 single byte 0x55, cycle-exact
        send(0, 8'h55, 1'b0, acc);
        tick();
        check("t1_line_edge1", {31'd0, tx[0]}, 32'd1);
        glitch = 0;
        frame = '0;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 16; j++) begin
                tick();
                if (j == 0) frame[b] = tx[0];
                else if (tx[0] !== frame[b]) glitch++;
                if (b == 9 && j == 14) check("t1_busy_hi", {31'd0, busy[0]}, 32'd1);
            end
        end
        check("t1_frame", {22'd0, frame}, 32'h2AA);
        check("t1_glitch", glitch, 0);
        check("t1_busy_fall", {31'd0, busy[0]}, 32'd0);
        check("t1_end_cycle", cyc - acc, 161);

        // Odd parity 0x03
        send(1, 8'h03, 1'b0, acc);
        recv(1, 1, 1, d, p, s1);
        check("t2a_latency", s1 - acc, 2);
        check("t2a_data", {24'd0, d}, 32'h03);
        check("t2a_parity", {31'd0, p}, 32'd1);
        while (cyc < acc + 176) tick();
        check("t2a_busy_176", {31'd0, busy[1]}, 32'd1);
        tick();
        check("t2a_busy_177", {31'd0, busy[1]}, 32'd0);
        check("t2a_level", {27'd0, lvl1}, 32'd0);

        // Even parity 0x07 then 0x03
        send(2, 8'h07, 1'b0, acc);
        recv(2, 1, 1, d, p, s1);
        check("t2b_data", {24'd0, d}, 32'h07);
        check("t2b_parity", {31'd0, p}, 32'd1);
        send(2, 8'h03, 1'b0, acc);
        recv(2, 1, 1, d, p, s1);
        check("t2c_data", {24'd0, d}, 32'h03);
        check("t2c_parity", {31'd0, p}, 32'd0);

        // EOL insertion after tlast
        send(3, 8'h41, 1'b1, acc);
        mon_k = 3;
        mon_en = 1'b1;
        recv(3, 0, 1, d, p, s1);
        check("t3_byte0", {24'd0, d}, 32'h41);
        recv(3, 0, 1, d, p, s2);
        check("t3_cr", {24'd0, d}, 32'h0D);
        recv(3, 0, 1, d, p, s3);
        check("t3_lf", {24'd0, d}, 32'h0A);
        mon_en = 1'b0;
        check("t3_gap1", s2 - s1, 161);
        check("t3_gap2", s3 - s2, 161);
        check("t3_busy_held", busy_low, 0);
        t = 0;
        while (busy[3] !== 1'b0 && t < 100) begin
            tick();
            t++;
        end
        check("t3_busy_drops", {31'd0, busy[3]}, 32'd0);
        check("t3_level", {27'd0, lvl3}, 32'd0);

        // Backpressure with a 4-deep FIFO
        fork
            begin
                tvalid[0] = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    tdata[0] = b4[i];
                    t = 0;
                    do begin
                        rdy = tready[0];
                        tick();
                        t++;
                    end while (!rdy && t < 500);
                    acc4[i] = cyc;
                    if (i == 4) begin
                        check("t4_tready_full", {31'd0, tready[0]}, 32'd0);
                        check("t4_level_full", {29'd0, lvl0}, 32'd4);
                    end
                end
                tvalid[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) recv(0, 0, 1, rx4[i], p, s1);
            end
        join
        for (int i = 1; i < 5; i++) check("t4_acc_burst", acc4[i] - acc4[0], i);
        check("t4_acc_sixth", acc4[5] - acc4[0], 163);
        for (int i = 0; i < 6; i++) check("t4_order", {24'd0, rx4[i]}, {24'd0, b4[i]});

        // Two stop bits, back to back
        send(4, 8'hA5, 1'b0, acc);
        send(4, 8'h5A, 1'b0, acc2);
        check("t5_second_next_cycle", acc2 - acc, 1);
        recv(4, 0, 2, d, p, s1);
        check("t5_byte0", {24'd0, d}, 32'hA5);
        recv(4, 0, 2, d, p, s2);
        check("t5_byte1", {24'd0, d}, 32'h5A);
        check("t5_spacing", s2 - s1, 177);

        // Reset in the middle of a frame with data still buffered
        while (busy[0] !== 1'b0 && t < 1000) begin
            tick();
            t++;
        end
        send(0, 8'h00, 1'b0, acc);
        send(0, 8'h00, 1'b0, acc2);
        while (cyc < acc + 70) tick();
        check("t6_line_low_before", {31'd0, tx[0]}, 32'd0);
        check("t6_level_before", {29'd0, lvl0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_line_async", {31'd0, tx[0]}, 32'd1);
        check("t6_level", {29'd0, lvl0}, 32'd0);
        check("t6_tready", {31'd0, tready[0]}, 32'd0);
        check("t6_busy", {31'd0, busy[0]}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_tready_after", {31'd0, tready[0]}, 32'd1);
        glitch = 0;
        repeat (400) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) glitch++;
        end
        check("t6_no_residual", glitch, 0);
        check("t6_level_after", {29'd0, lvl0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
